// File: rtl/imm_operand_encoder_pkg.sv
// Shared constants, FSM state type and helpers for the immediate operand encoder.
package imm_operand_encoder_pkg;

    // FSM states of the iterative encoder.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Field positions inside the 12-bit shift_operand.
    localparam int ROT_MSB   = 11;
    localparam int ROT_LSB   = 8;
    localparam int IMM8_MSB  = 7;
    localparam int MEM_OFF_W = 12;

    // Number of rotation candidates tried in rotated-immediate mode.
    localparam int ROT_STEPS = 16;

    // True when v is reproduced by sign-extending its low MEM_OFF_W bits,
    // i.e. every bit from the offset sign bit upward is identical.
    function automatic logic fits_mem_offset(input logic [31:0] v);
        return (&v[31:MEM_OFF_W-1]) | ~(|v[31:MEM_OFF_W-1]);
    endfunction

endpackage

// File: rtl/imm_operand_encoder_rot_candidate.sv
// Combinational rotation candidate: value rotated left by 2*rot, plus a flag
// saying the result fits in an 8-bit immediate. Also usable as a reference model.
import imm_operand_encoder_pkg::*;

module rot_candidate #(
    parameter int DATA_W = 32,
    parameter int ROT_W  = 4
) (
    input  logic [DATA_W-1:0] value,
    input  logic [ROT_W-1:0]  rot,
    output logic [DATA_W-1:0] cand,
    output logic              upper_zero
);

    logic [ROT_W:0]      shamt_s;
    logic [2*DATA_W-1:0] dbl_s;

    // Rotate by shifting a doubled copy; the upper half is the rotated word.
    always_comb begin
        shamt_s    = {rot, 1'b0};
        dbl_s      = {value, value} << shamt_s;
        cand       = dbl_s[2*DATA_W-1:DATA_W];
        upper_zero = (cand[DATA_W-1:IMM8_MSB+1] == '0);
    end

endmodule

// File: rtl/imm_operand_encoder.sv
// Iterative encoder: finds the 12-bit shift_operand field (rotated immediate
// or signed memory offset) that reproduces a 32-bit value.
import imm_operand_encoder_pkg::*;

module imm_operand_encoder #(
    parameter int DATA_W = 32,
    parameter int ROT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] value,
    input  logic              is_mem_instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       shift_operand,
    output logic              found
);

    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_STEPS - 1);
    localparam logic [ROT_W-1:0] ROT_INC  = {{(ROT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [DATA_W-1:0] val_r;
    logic              mode_r;
    logic [ROT_W-1:0]  rot_cnt_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [11:0]       shift_operand_r;
    logic              found_r;

    logic [DATA_W-1:0] cand_s;
    logic              upper_zero_s;
    logic              mem_fit_s;

    rot_candidate #(
        .DATA_W (DATA_W),
        .ROT_W  (ROT_W)
    ) u_rot_candidate (
        .value      (val_r),
        .rot        (rot_cnt_r),
        .cand       (cand_s),
        .upper_zero (upper_zero_s)
    );

    // Memory mode always evaluates with rot_cnt_r == 0, so cand_s equals val_r.
    always_comb begin
        mem_fit_s = fits_mem_offset(cand_s);
    end

    // Request/search/result FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            val_r           <= '0;
            mode_r          <= 1'b0;
            rot_cnt_r       <= '0;
            in_ready_r      <= 1'b1;
            out_valid_r     <= 1'b0;
            shift_operand_r <= 12'd0;
            found_r         <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        val_r      <= value;
                        mode_r     <= is_mem_instruction;
                        rot_cnt_r  <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (mode_r) begin
                        shift_operand_r <= mem_fit_s ? cand_s[MEM_OFF_W-1:0] : 12'd0;
                        found_r         <= mem_fit_s;
                        out_valid_r     <= 1'b1;
                        state_r         <= S_DONE;
                    end else if (upper_zero_s) begin
                        // First hit is the smallest rotation.
                        shift_operand_r[ROT_MSB:ROT_LSB] <= rot_cnt_r;
                        shift_operand_r[IMM8_MSB:0]      <= cand_s[IMM8_MSB:0];
                        found_r                          <= 1'b1;
                        out_valid_r                      <= 1'b1;
                        state_r                          <= S_DONE;
                    end else if (rot_cnt_r == ROT_LAST) begin
                        shift_operand_r <= 12'd0;
                        found_r         <= 1'b0;
                        out_valid_r     <= 1'b1;
                        state_r         <= S_DONE;
                    end else begin
                        rot_cnt_r <= rot_cnt_r + ROT_INC;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign shift_operand = shift_operand_r;
    assign found         = found_r;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Self-checking bench for imm_operand_encoder: vector table with a result
// scoreboard, plus hand-written backpressure and mid-operation reset sequences.
module tb_imm_operand_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic        is_mem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] shift_operand;
    logic        found;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] value;
        logic        is_mem;
        logic        exp_found;
        logic [11:0] exp_so;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        exp_found;
        logic [11:0] exp_so;
        int          exp_lat;
    } exp_t;

    vec_t vecs[10];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    imm_operand_encoder dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .value              (value),
        .is_mem_instruction (is_mem_instruction),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .shift_operand      (shift_operand),
        .found              (found)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Present a request and return just after the accept edge; then scramble
    // the inputs, which the encoder must ignore.
    task automatic accept(input logic [31:0] v, input logic m);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        value              = v;
        is_mem_instruction = m;
        in_valid           = 1'b1;
        @(posedge clk);
        #1;
        in_valid           = 1'b0;
        value              = ~v;
        is_mem_instruction = ~m;
    endtask

    // Sample at negedges; cycle n is the edge count after the accept edge.
    task automatic wait_result(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check("out_valid_timeout", 0, 1);
    endtask

    task automatic compare_result(input int cyc);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("latency", cyc, e.exp_lat);
            check("found", found, e.exp_found);
            check("shift_operand", shift_operand, e.exp_so);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_after_take", out_valid, 0);
        check("in_ready_after_take", in_ready, 1);
    endtask

    task automatic run_vec(input vec_t t);
        int cyc;
        sb_q.push_back('{t.exp_found, t.exp_so, t.exp_lat});
        accept(t.value, t.is_mem);
        wait_result(cyc);
        compare_result(cyc);
        consume();
    endtask

    initial begin
        int cyc;

        vecs[0] = '{32'h000000FF, 1'b0, 1'b1, 12'h0FF, 2};
        vecs[1] = '{32'h0003FC00, 1'b0, 1'b1, 12'hBFF, 13};
        vecs[2] = '{32'hF000000F, 1'b0, 1'b1, 12'h2FF, 4};
        vecs[3] = '{32'h00000101, 1'b0, 1'b0, 12'h000, 17};
        vecs[4] = '{32'h00000000, 1'b0, 1'b1, 12'h000, 2};
        vecs[5] = '{32'hFFFFF800, 1'b1, 1'b1, 12'h800, 2};
        vecs[6] = '{32'h000007FF, 1'b1, 1'b1, 12'h7FF, 2};
        vecs[7] = '{32'h00000800, 1'b1, 1'b0, 12'h000, 2};
        vecs[8] = '{32'hFF000000, 1'b0, 1'b1, 12'h4FF, 6};
        vecs[9] = '{32'hFFFFFFFF, 1'b1, 1'b1, 12'hFFF, 2};

        rst                = 1'b1;
        in_valid           = 1'b0;
        out_ready          = 1'b0;
        value              = 32'd0;
        is_mem_instruction = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_shift_operand", shift_operand, 0);
        check("reset_found", found, 0);

        // out_ready while idle has no effect.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_ready_out_valid", out_valid, 0);
        check("idle_out_ready_in_ready", in_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure plus an ignored request pulse during SEARCH.
        sb_q.push_back('{1'b1, 12'h2FF, 4});
        accept(32'hF000000F, 1'b0);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                value              = 32'h00000001;
                is_mem_instruction = 1'b0;
                in_valid           = 1'b1;
            end else if (i == 2) begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check("busy_out_valid_timeout", 0, 1);
        compare_result(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_shift_operand", shift_operand, 12'h2FF);
            check("hold_found", found, 1);
        end
        consume();
        repeat (3) begin
            @(negedge clk);
            check("no_queued_request", out_valid, 0);
        end

        // Reset in the middle of a non-matching search.
        accept(32'h00000101, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("pre_reset_out_valid", out_valid, 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_found", found, 0);
        check("midreset_shift_operand", shift_operand, 0);
        repeat (15) begin
            @(negedge clk);
            if (out_valid) check("aborted_request_output", out_valid, 0);
        end
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_operand_encoder.md
Name: imm_operand_encoder

Overview:
- Inverse of the execute-stage Val2 operand path. It takes a 32-bit value and searches iteratively for the 12-bit shift_operand field that reproduces it.
- Data-processing mode: finds {rotate_imm[3:0], imm8[7:0]} such that imm8 rotated right by 2*rotate_imm equals the value.
- Memory mode: checks whether the value fits the sign-extended 12-bit offset field.
- Used by the instruction-assembly/self-test path. It tests one rotation candidate per cycle behind a valid/ready handshake.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- ROT_W, 4, rotate_imm field width; 2**ROT_W candidates are tried.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  encoder idle; request is accepted when in_valid && in_ready.
- value  in  32  value to encode; sampled on accept.
- is_mem_instruction  in  1  1 = 12-bit signed offset encoding; 0 = rotated immediate; sampled on accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- shift_operand  out  12  encoded field; 0 when not found.
- found  out  1  1 = an encoding exists.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it has priority over all other activity.
- Reset values: state=IDLE, in_ready=1, out_valid=0, shift_operand=0, found=0, rot_cnt=0, latched value=0.
- FSM states: IDLE, SEARCH, DONE.
- IDLE: in_ready=1.
  - On accept: latch value and mode, clear rot_cnt, go to SEARCH.
  - in_valid without accept has no effect.
- SEARCH: in_ready=0. Each cycle evaluates cand = rotate_left(val_q, 2*rot_cnt), as a 32-bit rotate with no shift loss.
  - Rotated mode, cand[31:8]==0: register shift_operand={rot_cnt, cand[7:0]}, found=1, go to DONE. The smallest rotation wins.
  - Rotated mode, no match and rot_cnt==15: shift_operand=0, found=0, go to DONE.
  - Rotated mode, otherwise: rot_cnt increments by 1. There is no wrap-around; the search ends at 15.
  - Memory mode, single SEARCH cycle: if val_q[31:11] are all equal (all 0s or all 1s), shift_operand=val_q[11:0] and found=1; else shift_operand=0 and found=0. Go to DONE.
- DONE: out_valid=1, in_ready=0. shift_operand and found are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid goes 0 on the next cycle and the FSM returns to IDLE. in_ready rises that cycle; there is no same-cycle re-accept.
- Latency, with the accept edge at cycle 0:
  - Rotated match at rotation r: out_valid high from cycle r+2.
  - Rotated, no match: out_valid high from cycle 17.
  - Memory mode: out_valid high from cycle 2.
- Boundary cases:
  - value=0 encodes as rot 0, imm8 0, found=1.
  - Changes on value or is_mem_instruction after accept are ignored.
  - in_valid during SEARCH or DONE is ignored and not queued.
  - rst asserted mid-SEARCH or mid-DONE aborts the request with no output. out_valid=0 on the cycle after rst.
  - out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE=2'd0, S_SEARCH=2'd1, S_DONE=2'd2;
  - shift_operand field positions: ROT_MSB=11, ROT_LSB=8, IMM8_MSB=7, MEM_OFF_W=12;
  - ROT_STEPS=16.
- One sub-module, rot_candidate: combinational 32-bit rotate-left by 2*rot plus an "upper 24 bits zero" flag. It is reusable by the operand-generator bench as a reference model.

Test Plan:
- Rotated, value=0x000000FF -> found=1, shift_operand=0x0FF, out_valid at cycle 2.
- Rotated, value=0x0003FC00 -> found=1, shift_operand=0xBFF (rot 11), out_valid at cycle 13. value=0xF000000F -> shift_operand=0x2FF at cycle 4.
- Rotated, value=0x00000101 -> found=0, shift_operand=0x000, out_valid at cycle 17. value=0 -> found=1, shift_operand=0x000 at cycle 2.
- Memory mode: value=0xFFFFF800 -> found=1, 0x800; value=0x000007FF -> found=1, 0x7FF; value=0x00000800 -> found=0. All at cycle 2.
- Backpressure and busy: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Pulse in_valid with value=0x1 during SEARCH -> ignored; the original result is unchanged.
- Reset mid-operation: assert rst at cycle 5 of a 0x101 search -> next cycle state IDLE, in_ready=1, out_valid=0. A new request 0xFF then completes normally at cycle 2.
